// File: rtl/logic_gate_unit.sv
// Registered bitwise gate unit with valid/ready handshakes and optional
// multi-beat accumulate bursts folded into a single held result.
module logic_gate_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               parity_q, parity_d;
  logic [CNT_W-1:0]   ocount_q, ocount_d;
  logic               oovf_q, oovf_d;
  logic               accept;

  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = x | y;
      3'd1:    r = x & y;
      3'd2:    r = ~x;
      3'd3:    r = x ^ y;
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x & y);
      3'd6:    r = ~(x ^ y);
      default: r = (~x) ^ (x | y);
    endcase
    return r;
  endfunction

  assign in_ready   = (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign out_y      = y_q;
  assign out_parity = parity_q;
  assign out_count  = ocount_q;
  assign out_ovf    = oovf_q;
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    op_d     = op_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    y_d      = y_q;
    parity_d = parity_q;
    ocount_d = ocount_q;
    oovf_d   = oovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = gate_f(in_op, in_a, in_b);
          op_d    = in_op;
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (!in_acc || in_last) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = gate_f(op_q, acc_q, in_a);
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + CNT_W'(1);
          if (in_last) state_d = HOLD;
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
    // Result registers load only on entry to HOLD so they keep the last result elsewhere
    if (state_d == HOLD && state_q != HOLD) begin
      y_d      = acc_d;
      parity_d = ^acc_d;
      ocount_d = count_d;
      oovf_d   = ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      op_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      y_q      <= '0;
      parity_q <= 1'b0;
      ocount_q <= '0;
      oovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      y_q      <= y_d;
      parity_q <= parity_d;
      ocount_q <= ocount_d;
      oovf_q   <= oovf_d;
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed plan steps plus random
// bursts checked against a truth-table reference model.
module tb_logic_gate_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [2:0]    in_op;
  logic          in_acc, in_last;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_y;
  logic          out_parity;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int vectors = 0;
  int errors  = 0;

  // Per-op truth table, indexed by {x_bit, y_bit}
  logic [3:0] tt [8] = '{4'b1110, 4'b1000, 4'b0011, 4'b0110,
                         4'b0001, 4'b0111, 4'b1001, 4'b1101};

  logic [W-1:0] bq [$];

  logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_parity(out_parity),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_f(input logic [2:0] op,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = tt[op];
    for (int i = 0; i < int'(W); i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one beat at a negedge, let it be accepted, return at the next negedge.
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic acc, input logic last);
    chk("in_ready_before_beat", {31'b0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [W-1:0] y,
                               input int unsigned cnt, input logic ovf);
    chk({tag, "_valid"},  {31'b0, out_valid}, 32'd1);
    chk({tag, "_y"},      {24'b0, out_y}, {24'b0, y});
    chk({tag, "_parity"}, {31'b0, out_parity}, 32'($countones(y) % 2));
    chk({tag, "_count"},  {30'b0, out_count}, cnt);
    chk({tag, "_ovf"},    {31'b0, out_ovf}, {31'b0, ovf});
  endtask

  task automatic drain(input string tag, input int stall, input logic [W-1:0] y);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_hold_y"},     {24'b0, out_y}, {24'b0, y});
      chk({tag, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_drain_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_y"},     {24'b0, out_y}, 32'd0);
    chk({tag, "_par"},   {31'b0, out_parity}, 32'd0);
    chk({tag, "_count"}, {30'b0, out_count}, 32'd0);
    chk({tag, "_ovf"},   {31'b0, out_ovf}, 32'd0);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b, y;
    int           n, stall;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("por");

    // Single beats
    beat(8'h0F, 8'h33, 3'd7, 1'b0, 1'b0);
    expect_result("naox", 8'hCF, 1, 1'b0);
    drain("naox", 0, 8'hCF);
    beat(8'hA5, 8'hFF, 3'd3, 1'b0, 1'b1);
    expect_result("xor", 8'h5A, 1, 1'b0);
    // Backpressure on this result
    drain("bp", 5, 8'h5A);
    beat(8'h3C, 8'h99, 3'd2, 1'b0, 1'b0);
    expect_result("not", 8'hC3, 1, 1'b0);
    drain("not", 0, 8'hC3);

    // AND burst, in_op changes on later beats must not matter
    beat(8'hFF, 8'hF0, 3'd1, 1'b1, 1'b0);
    chk("and_mid_valid", {31'b0, out_valid}, 32'd0);
    beat(8'h3C, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("and_mid_valid2", {31'b0, out_valid}, 32'd0);
    beat(8'h18, 8'h00, 3'd6, 1'b1, 1'b1);
    expect_result("and", 8'h10, 3, 1'b0);
    drain("and", 1, 8'h10);

    // Saturating OR burst then single beat clears ovf
    beat(8'h01, 8'h00, 3'd0, 1'b1, 1'b0);
    beat(8'h02, 8'h00, 3'd0, 1'b1, 1'b0);
    beat(8'h04, 8'h00, 3'd0, 1'b1, 1'b0);
    beat(8'h08, 8'h00, 3'd0, 1'b1, 1'b0);
    beat(8'h10, 8'h00, 3'd0, 1'b1, 1'b1);
    expect_result("sat", 8'h1F, 3, 1'b1);
    drain("sat", 0, 8'h1F);
    beat(8'h55, 8'h0F, 3'd1, 1'b0, 1'b0);
    expect_result("post_sat", 8'h05, 1, 1'b0);
    drain("post_sat", 0, 8'h05);

    // Stalled AND burst matches unstalled result
    beat(8'hFF, 8'hF0, 3'd1, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, out_valid}, 32'd0);
    end
    beat(8'h3C, 8'h00, 3'd0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid2", {31'b0, out_valid}, 32'd0);
    end
    beat(8'h18, 8'h00, 3'd0, 1'b0, 1'b1);
    expect_result("stall", 8'h10, 3, 1'b0);
    drain("stall", 0, 8'h10);

    // Reset mid-burst
    beat(8'hAA, 8'h0F, 3'd3, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_burst");
    beat(8'hF0, 8'h3C, 3'd5, 1'b0, 1'b0);
    expect_result("after_rst", 8'hCF, 1, 1'b0);
    // Reset while holding a result
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_hold");

    // Random bursts against the reference model
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      n  = (($urandom % 2) == 0) ? 1 : int'($urandom_range(2, 6));
      bq.delete();
      a = W'($urandom); b = W'($urandom);
      y = model_f(op, a, b);
      beat(a, b, op, (n > 1), (n == 1) ? 1'($urandom) : 1'b0);
      for (int i = 1; i < n; i++) bq.push_back(W'($urandom));
      for (int i = 1; i < n; i++) begin
        stall = int'($urandom_range(0, 2));
        repeat (stall) @(negedge clk);
        chk("rnd_early_valid", {31'b0, out_valid}, 32'd0);
        a = bq.pop_front();
        y = model_f(op, y, a);
        beat(a, W'($urandom), 3'($urandom), 1'($urandom), (i == n - 1));
      end
      expect_result("rnd", y, (n > 3) ? 3 : n, (n > 3));
      drain("rnd", int'($urandom_range(0, 3)), y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
